// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor front end: instruction and
// timestep widths, sequencer state encoding and opcode field constants.
package proc_pkg;

  localparam int INSTR_W = 10;
  localparam int T_W     = 2;
  localparam logic [T_W-1:0] T_MAX = 2'd3;

  // Opcode lives in the top three bits; control_circuit decodes the same field.
  localparam int OP_MSB = 9;
  localparam int OP_LSB = 7;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_t;

  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small power-of-two instruction FIFO. Pointers carry an extra wrap bit so
// full and empty are decoded from the pointers alone; head data is combinational.
module instr_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INSTR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: a cleared pointer pair marks every slot invalid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/step_sequencer.sv
// Front-end sequencer: buffers instructions, holds the instruction register
// and steps the timestep counter for control_circuit until done or timeout.
module step_sequencer
  import proc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [INSTR_W-1:0] IN_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic               Run,
  input  logic               done,
  input  logic               ERR_CLR,
  output logic [INSTR_W-1:0] INSTR,
  output logic [T_W-1:0]     T,
  output logic               BUSY,
  output logic               ERR,
  output logic [CNT_W-1:0]   INSTR_CNT,
  output logic               EMPTY
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [T_W-1:0]   T_ONE   = {{(T_W-1){1'b0}}, 1'b1};

  seq_state_t         state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [T_W-1:0]     t_q;
  logic               busy_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               fifoFull;
  logic               fifoEmpty;
  logic [INSTR_W-1:0] fifoHead;
  logic               fetchEn;

  // Fetch depends only on registered state, Run and pointer-decoded empty.
  assign fetchEn = (state_q == IDLE) && Run && !fifoEmpty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Resetn),
    .push_i  (IN_VALID),
    .wdata_i (IN_DATA),
    .pop_i   (fetchEn),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign IN_READY  = !fifoFull;
  assign EMPTY     = fifoEmpty;
  assign INSTR     = instr_q;
  assign T         = t_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign INSTR_CNT = cnt_q;

  // ERR_CLR is applied first so a timeout set in the same cycle overrides it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      instr_q <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (ERR_CLR) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          t_q <= '0;
          if (fetchEn) begin
            instr_q <= fifoHead;
            t_q     <= T_ONE;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (done) begin
            t_q     <= '0;
            cnt_q   <= cnt_q + CNT_ONE;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (t_q == T_MAX) begin
            err_q   <= 1'b1;
            t_q     <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            t_q <= t_q + T_ONE;
          end
        end
        default: begin
          t_q     <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Front-end sequencing stage of the simple processor, directly upstream of `control_circuit`. It accepts 10-bit instructions over a valid/ready handshake into a small FIFO and holds the current instruction in the instruction register. It drives the `INSTR` and `T` inputs of `control_circuit`, and advances the 2-bit timestep counter until that block asserts `done`.

## Interface
- `DEPTH`, default 2: instruction FIFO entries; must be a power of two, ≥2.
- `CNT_W`, default 8: width of the retired-instruction counter.

- `Clock`  in  1  system clock, all state on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `IN_DATA`  in  10  instruction word from the loader.
- `IN_VALID`  in  1  `IN_DATA` is valid.
- `IN_READY`  out  1  FIFO can accept a word; equals `!full`. No dependence on pop in the same cycle.
- `Run`  in  1  level enable for fetching new instructions.
- `done`  in  1  from `control_circuit`; current instruction finished this step.
- `ERR_CLR`  in  1  synchronous clear of `ERR`.
- `INSTR`  out  10  instruction register contents; reset 0.
- `T`  out  2  timestep; reset 0.
- `BUSY`  out  1  high while in EXEC; reset 0.
- `ERR`  out  1  sticky timeout flag; reset 0.
- `INSTR_CNT`  out  `CNT_W`  count of retired instructions; reset 0; wraps.
- `EMPTY`  out  1  FIFO empty; reset 1.

## Operation
- Push: on an edge with `IN_VALID && IN_READY`, write `IN_DATA` to the tail. Words are never dropped or reordered.
- FSM states are IDLE and EXEC. Reset enters IDLE with `T`=0.
- IDLE:
  - `T`=0.
  - If `Run && !EMPTY`: pop the head into `INSTR`, set `T`←1, go to EXEC.
  - Otherwise hold. `INSTR` keeps its last value.
- EXEC:
  - If `done`: set `T`←0, `INSTR_CNT`←`INSTR_CNT`+1 (mod 2^`CNT_W`), go to IDLE.
  - Else if `T`==3: set `ERR`←1, `T`←0, go to IDLE. The instruction is abandoned and not counted.
  - Else `T`←`T`+1.
  - `done` is ignored in IDLE.
- `Run` deasserted mid-instruction: the current instruction runs to `done` or timeout. No further fetch occurs.
- `ERR_CLR` clears `ERR`. If a timeout and `ERR_CLR` occur in the same cycle, the set wins.
- No bypass: a word pushed at edge k is poppable at edge k+1 at the earliest.
- Simultaneous push and pop:
  - Full FIFO: push is blocked, because `IN_READY`=0.
  - Non-full FIFO: both happen and the occupancy is unchanged.
- Async reset at any point: FIFO emptied, all outputs return to their reset values immediately, and the in-flight instruction is lost.

## Timing
- Fetch latency: from a word pushed into an empty FIFO with `Run`=1, the next edge pops it, so `T`=1 and `INSTR` are valid one cycle after the push edge.
- LOAD/MOVE (`done` at `T`=1):
  - 2 cycles per instruction (EXEC, then IDLE).
  - Back-to-back throughput is one instruction per 2 cycles.
- ALU ops finishing at `T`=2: 3 cycles each.
- Worst case before timeout: `T`=1,2,3 then IDLE, i.e. 4 cycles.
- All outputs are registered except `IN_READY` and `EMPTY`, which are decoded from FIFO pointers only. There is no combinational path from `done` or `IN_VALID` to any output.

## Structure
- Shared package `proc_pkg`:
  - `INSTR_W`=10, `T_W`=2, `T_MAX`=2'd3.
  - `seq_state_t` enum {`IDLE`, `EXEC`}.
  - Opcode field constants (bits [9:7]) shared with `control_circuit`.
- Sub-module `instr_fifo`:
  - Parameterised depth.
  - Read/write pointers with an extra wrap bit.
  - Outputs `full`/`empty`; head data is available combinationally.
- `step_sequencer` holds the FSM, `T`, IR, counter and `ERR`.

## Test plan
- Reset mid-EXEC (`T`=2, FIFO holding 1 word), `Resetn`↓ → `T`=0, `INSTR`=0, `BUSY`=0, `EMPTY`=1, `IN_READY`=1 immediately.
- Push 10'h040 then 10'h0C5 with `Run`=1, `done` pulsed at each `T`=1:
  - `INSTR`=040 with `T` sequence 1,0.
  - Then `INSTR`=0C5 with `T` sequence 1,0.
  - `INSTR_CNT`=2.
- Push 3 words with `DEPTH`=2 and `Run`=0 → `IN_READY`=0 after 2 pushes, third word held by the source. Raise `Run` → all 3 retire in order.
- `done` never asserted → `T` sequence 1,2,3,0, `ERR`=1, `INSTR_CNT` unchanged. `ERR_CLR` on the next cycle → `ERR`=0.
- `Run` dropped while `T`=1, `done` at `T`=2 → instruction retires, FSM stays in IDLE with FIFO non-empty until `Run`=1.
- `CNT_W`=8, preload 255 retirements, retire one more → `INSTR_CNT`=0.
